// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round sequencer: state encoding,
// op_en bit positions, key length codes and round counts.
package aes_pkg;

  typedef enum logic [3:0] {
    KIDLE, KLOAD, KEXP, IDLE, LOAD, ARK0, SB, SR, MC, ARK, OUT
  } state_t;

  localparam int unsigned OP_SB  = 0;
  localparam int unsigned OP_SR  = 1;
  localparam int unsigned OP_MC  = 2;
  localparam int unsigned OP_ARK = 3;

  localparam logic [1:0] KEY_128  = 2'b00;
  localparam logic [1:0] KEY_192  = 2'b01;
  localparam logic [1:0] KEY_256  = 2'b10;
  localparam logic [1:0] KEY_RSVD = 2'b11;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  function automatic logic [3:0] nr_for(input logic [1:0] key_len);
    case (key_len)
      KEY_192: return NR_192;
      KEY_256: return NR_256;
      default: return NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Handshake, datapath-strobe and status bundle between the round sequencer
// (slave) and the host/datapath side (master).
interface aes_round_sequencer_if;
  logic       key_valid;
  logic [1:0] key_len;
  logic       key_ready;
  logic       blk_valid;
  logic       decrypt;
  logic       blk_ready;
  logic       out_valid;
  logic       out_ready;
  logic       load_key_en;
  logic       load_blk_en;
  logic       keyexp_en;
  logic       keyexp_done;
  logic [3:0] op_en;
  logic       inv;
  logic       op_done;
  logic [3:0] round_idx;
  logic       busy;
  logic       error;

  modport master (
    output key_valid, key_len, blk_valid, decrypt, out_ready, keyexp_done, op_done,
    input  key_ready, blk_ready, out_valid, load_key_en, load_blk_en, keyexp_en,
           op_en, inv, round_idx, busy, error
  );

  modport slave (
    input  key_valid, key_len, blk_valid, decrypt, out_ready, keyexp_done, op_done,
    output key_ready, blk_ready, out_valid, load_key_en, load_blk_en, keyexp_en,
           op_en, inv, round_idx, busy, error
  );
endinterface

// File: rtl/op_watchdog.sv
// Per-operation watchdog: counts cycles spent waiting for a done strobe and
// flags expiry on the cycle whose edge would take the count to all-ones.
module op_watchdog #(
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LAST = ~{{(TIMEOUT_W-1){1'b0}}, 1'b1};

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && !clr && (cnt == LAST);

endmodule

// File: rtl/aes_round_sequencer.sv
// AES round sequencer: key load/expansion, then per-block ARK0 plus Nr rounds
// of SB/SR/MC/ARK (inverse order for decrypt), with a per-operation watchdog.
//
// state | meaning
// KIDLE | no key expanded yet, accept key only
// KLOAD | one-cycle key load strobe
// KEXP  | key expansion running, wait keyexp_done
// IDLE  | key ready, accept new key or block
// LOAD  | one-cycle block load strobe
// ARK0  | initial AddRoundKey
// SB    | SubBytes (inverse when inv)
// SR    | ShiftRows (inverse when inv)
// MC    | MixColumns (inverse when inv)
// ARK   | AddRoundKey closing (enc) or mid (dec) round
// OUT   | result valid, wait out_ready
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int TIMEOUT_W   = 8,
  parameter int SUPPORT_DEC = 1
) (
  input logic            clk,
  input logic            n_rst,
  aes_round_sequencer_if.slave bus
);

  state_t     state;
  logic [3:0] nr;
  logic [3:0] round_idx;
  logic       inv;
  logic       error;
  logic [3:0] op_en;
  logic       waiting;
  logic       done_hit;
  logic       wd_clr;
  logic       wd_expired;
  logic       final_round;
  logic       key_bad;

  assign waiting     = state inside {KEXP, ARK0, SB, SR, MC, ARK};
  assign done_hit    = (state == KEXP) ? bus.keyexp_done : (waiting && bus.op_done);
  // Clearing whenever not waiting or advancing makes every wait state start at zero.
  assign wd_clr      = !waiting || done_hit;
  assign final_round = (round_idx == nr);
  assign key_bad     = (bus.key_len == KEY_RSVD);

  op_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr     (wd_clr),
    .en      (waiting),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= KIDLE;
      nr        <= NR_128;
      round_idx <= '0;
      inv       <= 1'b0;
      error     <= 1'b0;
    end else begin
      error <= 1'b0;
      if (wd_expired) begin
        error <= 1'b1;
        state <= (state == KEXP) ? KIDLE : IDLE;
      end else begin
        case (state)
          KIDLE, IDLE: begin
            if (bus.key_valid) begin
              if (key_bad) begin
                error <= 1'b1;
              end else begin
                nr    <= nr_for(bus.key_len);
                state <= KLOAD;
              end
            end else if ((state == IDLE) && bus.blk_valid) begin
              inv       <= bus.decrypt && (SUPPORT_DEC != 0);
              round_idx <= '0;
              state     <= LOAD;
            end
          end
          KLOAD: state <= KEXP;
          KEXP:  if (bus.keyexp_done) state <= IDLE;
          LOAD:  state <= ARK0;
          ARK0: begin
            if (bus.op_done) begin
              round_idx <= round_idx + 4'd1;
              state     <= inv ? SR : SB;
            end
          end
          SB: if (bus.op_done) state <= inv ? ARK : SR;
          SR: begin
            if (bus.op_done) begin
              if (inv)              state <= SB;
              else if (final_round) state <= ARK;
              else                  state <= MC;
            end
          end
          MC: begin
            if (bus.op_done) begin
              if (inv) begin
                round_idx <= round_idx + 4'd1;
                state     <= SR;
              end else begin
                state <= ARK;
              end
            end
          end
          ARK: begin
            if (bus.op_done) begin
              if (final_round) begin
                state <= OUT;
              end else if (inv) begin
                state <= MC;
              end else begin
                round_idx <= round_idx + 4'd1;
                state     <= SB;
              end
            end
          end
          OUT:     if (bus.out_ready) state <= IDLE;
          default: state <= KIDLE;
        endcase
      end
    end
  end

  always_comb begin
    op_en = '0;
    case (state)
      ARK0, ARK: op_en[OP_ARK] = 1'b1;
      MC:        op_en[OP_MC]  = 1'b1;
      SR:        op_en[OP_SR]  = 1'b1;
      SB:        op_en[OP_SB]  = 1'b1;
      default:   op_en = '0;
    endcase
  end

  assign bus.op_en       = op_en;
  assign bus.key_ready   = (state == KIDLE) || (state == IDLE);
  assign bus.blk_ready   = (state == IDLE);
  assign bus.out_valid   = (state == OUT);
  assign bus.load_key_en = (state == KLOAD);
  assign bus.load_blk_en = (state == LOAD);
  assign bus.keyexp_en   = (state == KEXP);
  assign bus.busy        = !((state == KIDLE) || (state == IDLE) || (state == OUT));
  assign bus.inv         = inv;
  assign bus.round_idx   = round_idx;
  assign bus.error       = error;

endmodule
